cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Two-requester arbiter in front of the single-ported `cache` block. It shares the cache's `data/addr/wr/q` access port between an instruction-fetch requester (port 0) and a load/store requester (port 1). Arbitration is round-robin with a per-port request/acknowledge handshake. A watchdog terminates any cache access that never completes.

## Interface
Parameters:
- `DATA_W`, 32: data width, all ports.
- `ADDR_W`, 32: address width, all ports.
- `TIMEOUT`, 255: WAIT cycles before an access is aborted (1..65535).

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req0` / `req1`, in, 1: access request, held until matching ack.
- `wr0` / `wr1`, in, 1: 1 = write, 0 = read; stable while req high.
- `addr0` / `addr1`, in, ADDR_W: word address; stable while req high.
- `wdata0` / `wdata1`, in, DATA_W: write data; stable while req high.
- `ack0` / `ack1`, out, 1: one-cycle completion pulse.
- `q0` / `q1`, out, DATA_W: read data; valid in the ack cycle, held after.
- `err0` / `err1`, out, 1: high with ack when the access timed out.
- `mem_req`, out, 1: one-cycle strobe that starts a cache access.
- `mem_wr`, `mem_addr`, `mem_data`, out, 1/ADDR_W/DATA_W: latched command; stable from ISSUE through DONE.
- `mem_ready`, in, 1: cache completion; `mem_q` valid in the same cycle.
- `mem_q`, in, DATA_W: cache read data.

## Operation
FSM states are IDLE, ISSUE, WAIT and DONE.
- **IDLE**:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not granted last. After reset, port 0 wins.
  - On grant: latch the winner's wr/addr/wdata into the `mem_*` registers, record `gnt`, go to ISSUE.
- **ISSUE**: `mem_req`=1 for exactly this cycle. `mem_ready` is ignored. Go to WAIT and clear the watchdog to 0.
- **WAIT**:
  - On `mem_ready`=1: for a read, capture `mem_q` into `q[gnt]`; for a write, `q[gnt]` is unchanged. Go to DONE.
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT, go to DONE with the timeout flag set.
- **DONE**:
  - `ack[gnt]`=1. `err[gnt]` equals the timeout flag.
  - A timed-out read loads `q[gnt]` with 0.
  - Update the round-robin pointer to `gnt`, then go to IDLE.
- Requesters sample ack at the edge closing DONE and drop or change req at that same edge. IDLE therefore never re-grants a completed request.
- The non-granted port's req is held pending and is not lost. It wins the next IDLE whenever the granted port re-requests.
- A `mem_ready` arriving outside WAIT is ignored and is not counted.
- Changing req/wr/addr/wdata while req is high and unacked is a protocol violation. It does not need to be handled.

## Timing
- Reset (async assert, sync release) puts the FSM in IDLE and clears the pointer (port 0 priority) and the watchdog.
- Every output resets to 0, including `q0`/`q1`, `mem_*` and `err*`.
- Any transaction in flight at reset is abandoned and no ack is issued.
- Minimum latency: req sampled at edge k → ISSUE in cycle k+1 → WAIT in k+2 (with `mem_ready`) → ack in cycle k+3.
- Access latency is 3 + (WAIT cycles − 1). A timed-out access acks TIMEOUT+3 cycles after req.
- Back-to-back grants: a new ISSUE no earlier than 2 cycles after DONE (DONE → IDLE → ISSUE).
- The watchdog is 16 bits wide and saturates. The compare is `cnt == TIMEOUT−1` registered.
- `ack0` and `ack1` are never high in the same cycle.

## Structure
- Package `cache_arb_pkg`:
  - state enum `{IDLE, ISSUE, WAIT, DONE}`
  - `NUM_PORTS = 2`
  - watchdog counter width `WD_W = 16`
- Sub-module `cache_arb_rr`: combinational 2-way round-robin pick. Inputs are `req[1:0]` and `last_gnt`; outputs are `gnt` and `valid`.
- Datapath latches and the FSM live in the top module.

## Test plan
- Reset then `req0` only, read addr 0x10, cache returns 0xDEADBEEF 1 cycle after `mem_req` → `mem_req` at k+1, `ack0` at k+3, `q0`=0xDEADBEEF, `err0`=0.
- `req0` and `req1` both rise together, repeated 4 times → grant order 0,1,0,1. Exactly one ack per DONE.
- `req1` write addr 0x4, data 0x12345678 → `mem_wr`=1, `mem_data`=0x12345678 stable ISSUE..DONE; `ack1` pulse; `q1` unchanged.
- TIMEOUT=8, cache never asserts `mem_ready` → `ack0` and `err0` high at cycle k+11; `q0`=0; FSM returns to IDLE.
- Spurious `mem_ready` in IDLE and ISSUE → no ack and no q change.
- `rst` asserted during WAIT → all outputs 0 asynchronously. After release, a pending `req1` is still served, with port 0 priority restored.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache arbiter.
// The state enum drives the arbiter FSM; WD_W sizes the access watchdog.
package cache_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int WD_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

endpackage

// File: rtl/cache_arb_rr.sv
// Combinational two-way round-robin pick.
// When both ports request, the port that was not granted last wins.
module cache_arb_rr
    import cache_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last_gnt,
    output logic                 gnt,
    output logic                 valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_gnt;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache access port between instruction fetch (port 0)
// and load/store (port 1), with round-robin arbitration and an access watchdog.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] q0,
    output logic              err0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] q1,
    output logic              err1,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              served_q, served_d;
    logic [WD_W-1:0]   cnt_q, cnt_d;
    logic              at_limit_q, at_limit_d;
    logic              timeout_q, timeout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] q0_q, q0_d;
    logic [DATA_W-1:0] q1_q, q1_d;

    logic rr_gnt;
    logic rr_valid;
    logic rr_last;

    // Until the first access completes, pretend port 1 went last so port 0 wins.
    assign rr_last = served_q ? last_gnt_q : 1'b1;

    cache_arb_rr u_rr (
        .req      ({req1, req0}),
        .last_gnt (rr_last),
        .gnt      (rr_gnt),
        .valid    (rr_valid)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        served_d   = served_q;
        cnt_d      = cnt_q;
        at_limit_d = at_limit_q;
        timeout_d  = timeout_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        q0_d       = q0_q;
        q1_d       = q1_q;

        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    gnt_d      = rr_gnt;
                    mem_wr_d   = rr_gnt ? wr1    : wr0;
                    mem_addr_d = rr_gnt ? addr1  : addr0;
                    mem_data_d = rr_gnt ? wdata1 : wdata0;
                    timeout_d  = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d      = '0;
                at_limit_d = 1'b0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A completion in the same cycle as the watchdog limit still counts as success.
                if (mem_ready) begin
                    if (!mem_wr_q) begin
                        if (gnt_q) q1_d = mem_q;
                        else       q0_d = mem_q;
                    end
                    state_d = DONE;
                end else if (at_limit_q) begin
                    timeout_d = 1'b1;
                    if (!mem_wr_q) begin
                        if (gnt_q) q1_d = '0;
                        else       q0_d = '0;
                    end
                    state_d = DONE;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + WD_W'(1);
                    at_limit_d = (cnt_q == LIMIT);
                end
            end
            DONE: begin
                last_gnt_d = gnt_q;
                served_d   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b0;
            served_q   <= 1'b0;
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
            timeout_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            served_q   <= served_d;
            cnt_q      <= cnt_d;
            at_limit_q <= at_limit_d;
            timeout_q  <= timeout_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
        end
    end

    assign mem_req  = (state_q == ISSUE);
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign ack0     = (state_q == DONE) && !gnt_q;
    assign ack1     = (state_q == DONE) &&  gnt_q;
    assign err0     = ack0 && timeout_q;
    assign err1     = ack1 && timeout_q;
    assign q0       = q0_q;
    assign q1       = q1_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of arbitration, latency and watchdog.
module tb_cache_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, wr0, req1, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, err0, err1;
    logic [DATA_W-1:0] q0, q1;
    logic              mem_req, mem_wr, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data, mem_q;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: pending requests, their commands, read results, last winner.
    bit          reqState [2];
    bit          cmdWr    [2];
    logic [31:0] cmdAddr  [2];
    logic [31:0] cmdData  [2];
    logic [31:0] expQ     [2];
    int          lastGnt = -1;

    cache_port_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .q0        (q0),
        .err0      (err0),
        .req1      (req1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .q1        (q1),
        .err1      (err1),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCmd(input string tag, input int win);
        checkOutput({tag, "_mem_wr"},   mem_wr,   cmdWr[win]);
        checkOutput({tag, "_mem_addr"}, mem_addr, cmdAddr[win]);
        checkOutput({tag, "_mem_data"}, mem_data, cmdData[win]);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_ack"}, {ack1, ack0}, 2'b00);
        checkOutput({tag, "_q0"}, q0, expQ[0]);
        checkOutput({tag, "_q1"}, q1, expQ[1]);
    endtask

    task automatic applyStimulus(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        cmdWr[port]    = wr;
        cmdAddr[port]  = addr;
        cmdData[port]  = data;
        reqState[port] = 1'b1;
        if (port == 0) begin
            req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = data;
        end else begin
            req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = data;
        end
    endtask

    task automatic dropReq(input int port);
        reqState[port] = 1'b0;
        if (port == 0) req0 = 1'b0;
        else           req1 = 1'b0;
    endtask

    task automatic raiseRandom(input int port);
        applyStimulus(port, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // Called at a negedge in IDLE with requests driven; returns at the negedge of the following IDLE cycle.
    // delay = WAIT cycle index in which the cache answers; negative or above TIMEOUT means never.
    task automatic runAccess(input int delay, input logic [31:0] rdata, input bit spurIssue);
        int       win;
        int       waitCycles;
        bit       timedOut;
        bit [1:0] expAck;
        if (reqState[0] && reqState[1]) win = (lastGnt == 0) ? 1 : 0;
        else                            win = reqState[1] ? 1 : 0;
        timedOut   = (delay < 0) || (delay > TIMEOUT);
        waitCycles = timedOut ? TIMEOUT + 1 : delay + 1;

        @(negedge clk);
        mem_ready = spurIssue;
        mem_q     = ~rdata;
        checkOutput("issue_mem_req", mem_req, 1);
        checkOutput("issue_ack", {ack1, ack0}, 2'b00);
        checkCmd("issue", win);

        for (int w = 0; w < waitCycles; w++) begin
            @(negedge clk);
            mem_ready = !timedOut && (w == delay);
            mem_q     = mem_ready ? rdata : $urandom;
            checkOutput("wait_mem_req", mem_req, 0);
            checkOutput("wait_ack", {ack1, ack0}, 2'b00);
            checkCmd("wait", win);
        end

        @(negedge clk);
        mem_ready = 1'b0;
        if (!cmdWr[win]) expQ[win] = timedOut ? 32'h0 : rdata;
        expAck = (win == 1) ? 2'b10 : 2'b01;
        checkOutput("done_ack", {ack1, ack0}, expAck);
        checkOutput("done_err", {err1, err0}, timedOut ? expAck : 2'b00);
        checkOutput("done_q0", q0, expQ[0]);
        checkOutput("done_q1", q1, expQ[1]);
        checkCmd("done", win);
        dropReq(win);
        lastGnt = win;

        @(negedge clk);
        checkQuiet("post_done");
        checkOutput("post_done_err", {err1, err0}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int d;
        rst = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        mem_ready = 1'b0; mem_q = '0;
        expQ[0] = '0; expQ[1] = '0;

        @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset_err", {err1, err0}, 2'b00);
        checkOutput("reset_mem_cmd", {mem_wr, mem_addr, mem_data}, 65'h0);
        rst = 1'b0;
        @(negedge clk);
        checkQuiet("idle_after_reset");

        $display("[TB] single read, minimum latency");
        applyStimulus(0, 1'b0, 32'h10, 32'h0);
        runAccess(0, 32'hDEADBEEF, 1'b0);

        $display("[TB] simultaneous requests, alternating grants");
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 2; p++) if (!reqState[p]) raiseRandom(p);
            runAccess(int'($urandom_range(0, 3)), $urandom, 1'b0);
        end
        while (reqState[0] || reqState[1]) runAccess(1, $urandom, 1'b0);

        $display("[TB] port 1 write");
        applyStimulus(1, 1'b1, 32'h4, 32'h12345678);
        runAccess(2, 32'hFFFF0000, 1'b0);

        $display("[TB] watchdog expiry on a read");
        applyStimulus(0, 1'b0, 32'h20, 32'h0);
        runAccess(1, 32'h5A5A5A5A, 1'b0);
        applyStimulus(0, 1'b0, 32'h24, 32'h0);
        runAccess(-1, 32'h0, 1'b0);

        $display("[TB] completion on the watchdog limit cycle");
        applyStimulus(1, 1'b0, 32'h28, 32'h0);
        runAccess(TIMEOUT, 32'h0F0F1234, 1'b0);

        $display("[TB] spurious mem_ready in IDLE and ISSUE");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            mem_q     = $urandom;
            checkQuiet("spurious_idle");
        end
        @(negedge clk);
        mem_ready = 1'b0;
        checkQuiet("spurious_idle_end");
        applyStimulus(0, 1'b0, 32'h30, 32'h0);
        runAccess(3, 32'hC0FFEE00, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            for (int p = 0; p < 2; p++) if (!reqState[p] && $urandom_range(0, 2) != 0) raiseRandom(p);
            if (!reqState[0] && !reqState[1]) raiseRandom(int'($urandom_range(0, 1)));
            d = int'($urandom_range(0, TIMEOUT + 3));
            runAccess(d, $urandom, $urandom_range(0, 3) == 0);
        end
        while (reqState[0] || reqState[1]) runAccess(0, $urandom, 1'b0);

        $display("[TB] reset during WAIT");
        applyStimulus(1, 1'b0, 32'h44, 32'h0);
        runAccess(0, 32'h11112222, 1'b0);
        applyStimulus(0, 1'b0, 32'h48, 32'h0);
        runAccess(0, 32'h33334444, 1'b0);
        applyStimulus(1, 1'b1, 32'h40, 32'h0BADF00D);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expQ[0] = '0;
        expQ[1] = '0;
        lastGnt = -1;
        checkQuiet("async_reset");
        checkOutput("async_reset_err", {err1, err0}, 2'b00);
        checkOutput("async_reset_mem_cmd", {mem_wr, mem_addr, mem_data}, 65'h0);
        @(negedge clk);
        checkQuiet("held_reset");
        rst = 1'b0;
        applyStimulus(0, 1'b0, 32'h80, 32'h0);
        runAccess(1, 32'h77778888, 1'b0);
        runAccess(0, 32'h99990000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
